// File: rtl/cfu_arbiter_pkg.sv
// rtl/cfu_arbiter_pkg.sv - shared types and default widths for the Cfu arbiter
package cfu_arbiter_pkg;

    localparam int DEFAULT_NREQ   = 2;
    localparam int DEFAULT_FUNC_W = 10;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DELIVER  = 2'd3
    } arb_state_t;

    // Command as seen on the Cfu port at the default widths
    typedef struct packed {
        logic [DEFAULT_FUNC_W-1:0] function_id;
        logic [DEFAULT_DATA_W-1:0] inputs_0;
        logic [DEFAULT_DATA_W-1:0] inputs_1;
    } cfu_cmd_t;

endpackage

// File: rtl/cfu_rr_pick.sv
// rtl/cfu_rr_pick.sv - combinational round-robin selector starting at a pointer
module cfu_rr_pick
    import cfu_arbiter_pkg::*;
#(
    parameter int  N  = DEFAULT_NREQ,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk from ptr upward with wrap; the first active request found wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int d = 0; d < N; d++) begin
            sum = {1'b0, ptr} + (IW+1)'(d);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/cfu_arbiter.sv
// rtl/cfu_arbiter.sv - round-robin arbiter sharing one Cfu between NREQ requesters
module cfu_arbiter
    import cfu_arbiter_pkg::*;
#(
    parameter int  NREQ   = DEFAULT_NREQ,
    parameter int  FUNC_W = DEFAULT_FUNC_W,
    parameter int  DATA_W = DEFAULT_DATA_W,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_cmd_valid,
    output logic [NREQ-1:0]              req_cmd_ready,
    input  logic [NREQ-1:0][FUNC_W-1:0]  req_cmd_function_id,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_cmd_inputs_0,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_cmd_inputs_1,
    input  logic [NREQ-1:0]              req_lock,
    output logic [NREQ-1:0]              req_rsp_valid,
    input  logic [NREQ-1:0]              req_rsp_ready,
    output logic [DATA_W-1:0]            req_rsp_outputs_0,
    output logic                         cmd_valid,
    output logic [FUNC_W-1:0]            cmd_payload_function_id,
    output logic [DATA_W-1:0]            cmd_payload_inputs_0,
    output logic [DATA_W-1:0]            cmd_payload_inputs_1,
    input  logic                         cmd_ready,
    input  logic                         rsp_valid,
    input  logic [DATA_W-1:0]            rsp_payload_outputs_0,
    output logic                         rsp_ready,
    output logic [IW-1:0]                owner,
    output logic                         busy
);

    typedef struct packed {
        logic [FUNC_W-1:0] function_id;
        logic [DATA_W-1:0] inputs_0;
        logic [DATA_W-1:0] inputs_1;
    } cmd_t;

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              lock_held_q, lock_held_d;
    cmd_t              payload_q, payload_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    // While a lock is held only the lock owner competes; nothing is accepted during reset
    always_comb begin
        eligible = req_cmd_valid;
        if (lock_held_q) begin
            eligible           = '0;
            eligible[owner_q]  = req_cmd_valid[owner_q];
        end
        if (reset) begin
            eligible = '0;
        end
    end

    cfu_rr_pick #(.N(NREQ)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Transaction sequencing: accept, issue to Cfu, collect result, hand it back
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        lock_held_d   = lock_held_q;
        payload_d     = payload_q;
        rsp_data_d    = rsp_data_q;
        req_cmd_ready = '0;
        req_rsp_valid = '0;
        cmd_valid     = 1'b0;
        rsp_ready     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_cmd_ready         = pick_grant;
                    payload_d.function_id = req_cmd_function_id[pick_idx];
                    payload_d.inputs_0    = req_cmd_inputs_0[pick_idx];
                    payload_d.inputs_1    = req_cmd_inputs_1[pick_idx];
                    owner_d               = pick_idx;
                    state_d               = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    rsp_data_d = rsp_payload_outputs_0;
                    state_d    = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                req_rsp_valid[owner_q] = 1'b1;
                if (req_rsp_ready[owner_q]) begin
                    state_d     = ST_IDLE;
                    rr_ptr_d    = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + IW'(1);
                    lock_held_d = req_lock[owner_q];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction and the lock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            lock_held_q <= 1'b0;
            payload_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_held_q <= lock_held_d;
            payload_q   <= payload_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_payload_function_id = payload_q.function_id;
    assign cmd_payload_inputs_0    = payload_q.inputs_0;
    assign cmd_payload_inputs_1    = payload_q.inputs_1;
    assign req_rsp_outputs_0       = rsp_data_q;
    assign owner                   = owner_q;
    assign busy                    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cfu_arbiter.sv
// tb/tb_cfu_arbiter.sv - self-checking bench for cfu_arbiter
module tb_cfu_arbiter;
    import cfu_arbiter_pkg::*;

    localparam int NREQ   = 3;
    localparam int FUNC_W = 10;
    localparam int DATA_W = 32;
    localparam int IW     = $clog2(NREQ);

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NREQ-1:0]             req_cmd_valid, req_cmd_ready, req_lock, req_rsp_valid, req_rsp_ready;
    logic [NREQ-1:0][FUNC_W-1:0] req_cmd_function_id;
    logic [NREQ-1:0][DATA_W-1:0] req_cmd_inputs_0, req_cmd_inputs_1;
    logic [DATA_W-1:0]           req_rsp_outputs_0;
    logic                        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [FUNC_W-1:0]           cmd_payload_function_id;
    logic [DATA_W-1:0]           cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_payload_outputs_0;
    logic [IW-1:0]               owner;

    always #5 clk = ~clk;

    cfu_arbiter #(.NREQ(NREQ), .FUNC_W(FUNC_W), .DATA_W(DATA_W)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .req_cmd_valid           (req_cmd_valid),
        .req_cmd_ready           (req_cmd_ready),
        .req_cmd_function_id     (req_cmd_function_id),
        .req_cmd_inputs_0        (req_cmd_inputs_0),
        .req_cmd_inputs_1        (req_cmd_inputs_1),
        .req_lock                (req_lock),
        .req_rsp_valid           (req_rsp_valid),
        .req_rsp_ready           (req_rsp_ready),
        .req_rsp_outputs_0       (req_rsp_outputs_0),
        .cmd_valid               (cmd_valid),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .cmd_ready               (cmd_ready),
        .rsp_valid               (rsp_valid),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .rsp_ready               (rsp_ready),
        .owner                   (owner),
        .busy                    (busy)
    );

    typedef struct {
        cfu_cmd_t cmd;
        logic     lock;
    } rcmd_t;

    typedef struct {
        int          req;
        rcmd_t       c;
        int          acc_cyc;
        int          rsp_cyc;
        int          done_cyc;
        logic [31:0] data;
        bit          got;
    } txn_t;

    typedef struct {
        int          req;
        logic [9:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    rcmd_t          pend[NREQ][$];
    bit             inflight[NREQ];
    logic [31:0]    cfu_q[$];
    logic [31:0]    mac_acc;
    bit             cfu_cmd_rdy, cfu_rsp_en;
    bit [NREQ-1:0]  rsp_rdy_en;
    txn_t           log_q[$];
    txn_t           cur;
    bit             cur_valid;
    int             m_ptr, m_owner;
    bit             m_lock;
    int             checks = 0, errors = 0, cyc = 0;
    vec_t           vt[5];

    task automatic check_eq(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench Cfu: a few arithmetic ops plus a multiply-accumulate register
    function automatic logic [31:0] cfu_op(cfu_cmd_t c);
        logic [31:0] r;
        case (c.function_id)
            10'h007: r = c.inputs_0 + c.inputs_1;
            10'h00F: r = c.inputs_0 - c.inputs_1;
            10'h017: r = c.inputs_0 * c.inputs_1;
            10'h000: begin mac_acc = mac_acc + c.inputs_0 * c.inputs_1; r = mac_acc; end
            10'h008: begin r = mac_acc; mac_acc = '0; end
            default: r = c.inputs_0 ^ c.inputs_1;
        endcase
        return r;
    endfunction

    // Arbitration rule: lock owner only while locked, else nearest requester at or after the pointer
    function automatic int model_pick(logic [NREQ-1:0] v);
        if (m_lock) return v[m_owner] ? m_owner : -1;
        for (int d = 0; d < NREQ; d++) begin
            if (v[(m_ptr + d) % NREQ]) return (m_ptr + d) % NREQ;
        end
        return -1;
    endfunction

    task automatic push_cmd(int r, logic [9:0] f, logic [31:0] a, logic [31:0] b, logic lk);
        rcmd_t c;
        c.cmd.function_id = f;
        c.cmd.inputs_0    = a;
        c.cmd.inputs_1    = b;
        c.lock            = lk;
        pend[r].push_back(c);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i].size() > 0 && !inflight[i]) begin
                req_cmd_valid[i]       = 1'b1;
                req_cmd_function_id[i] = pend[i][0].cmd.function_id;
                req_cmd_inputs_0[i]    = pend[i][0].cmd.inputs_0;
                req_cmd_inputs_1[i]    = pend[i][0].cmd.inputs_1;
            end else begin
                req_cmd_valid[i]       = 1'b0;
                req_cmd_function_id[i] = FUNC_W'($urandom);
                req_cmd_inputs_0[i]    = $urandom;
                req_cmd_inputs_1[i]    = $urandom;
            end
            req_lock[i]      = (pend[i].size() > 0) ? pend[i][0].lock : 1'b0;
            req_rsp_ready[i] = rsp_rdy_en[i];
        end
        cmd_ready             = cfu_cmd_rdy;
        rsp_valid             = cfu_rsp_en && (cfu_q.size() > 0);
        rsp_payload_outputs_0 = (cfu_q.size() > 0) ? cfu_q[0] : '0;
    endtask

    task automatic tick();
        int            pick;
        logic [NREQ-1:0] exp_rdy, own;
        bit            cmd_f, rsp_f, dlv;
        drive();
        #1;
        exp_rdy = '0;
        pick    = -1;
        dlv     = 1'b0;
        if (!cur_valid) begin
            pick = model_pick(req_cmd_valid);
            if (pick >= 0) exp_rdy[pick] = 1'b1;
        end
        check_eq("req_cmd_ready", req_cmd_ready, exp_rdy);
        check_eq("busy", busy, cur_valid);
        check_eq("cmd_rsp_exclusive", cmd_valid & rsp_ready, 0);
        if (cur_valid) begin
            check_eq("owner", owner, cur.req);
            if (cmd_valid)
                check_eq("cmd_payload", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, cur.c.cmd);
            own = '0;
            own[cur.req] = 1'b1;
            check_eq("rsp_valid_non_owner", req_rsp_valid & ~own, 0);
            if (req_rsp_valid[cur.req]) begin
                check_eq("rsp_before_cfu", cur.got, 1);
                check_eq("rsp_data", req_rsp_outputs_0, cur.data);
                if (cur.rsp_cyc < 0) cur.rsp_cyc = cyc;
                dlv = req_rsp_ready[cur.req];
            end
        end else begin
            check_eq("idle_outputs", {cmd_valid, rsp_ready, req_rsp_valid}, 0);
        end
        cmd_f = cmd_valid && cmd_ready;
        rsp_f = rsp_valid && rsp_ready;
        @(posedge clk);
        #1;
        if (pick >= 0) begin
            cur.req      = pick;
            cur.c        = pend[pick][0];
            cur.acc_cyc  = cyc;
            cur.rsp_cyc  = -1;
            cur.done_cyc = -1;
            cur.data     = '0;
            cur.got      = 1'b0;
            cur_valid    = 1'b1;
            inflight[pick] = 1'b1;
        end
        if (cmd_f && cur_valid) cfu_q.push_back(cfu_op(cur.c.cmd));
        if (rsp_f && cfu_q.size() > 0) begin
            cur.data = cfu_q.pop_front();
            cur.got  = 1'b1;
        end
        if (dlv) begin
            m_ptr        = (cur.req + 1) % NREQ;
            m_lock       = pend[cur.req][0].lock;
            m_owner      = cur.req;
            cur.done_cyc = cyc;
            log_q.push_back(cur);
            void'(pend[cur.req].pop_front());
            inflight[cur.req] = 1'b0;
            cur_valid    = 1'b0;
        end
        cyc++;
    endtask

    function automatic bit work_left();
        bit w = cur_valid;
        for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) w = 1'b1;
        return w;
    endfunction

    task automatic run_until_idle(int budget);
        int n = 0;
        while (work_left() && n < budget) begin
            tick();
            n++;
        end
        if (work_left()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check_eq({tag, "_req_cmd_ready"}, req_cmd_ready, 0);
        check_eq({tag, "_req_rsp_valid"}, req_rsp_valid, 0);
        check_eq({tag, "_cfu_ctrl"}, {cmd_valid, rsp_ready, busy}, 0);
        check_eq({tag, "_payload"}, {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, 0);
        check_eq({tag, "_rsp_data"}, req_rsp_outputs_0, 0);
        check_eq({tag, "_owner"}, owner, 0);
    endtask

    task automatic reset_model();
        if (cur_valid) void'(pend[cur.req].pop_front());
        cur_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) inflight[i] = 1'b0;
        cfu_q.delete();
        mac_acc = '0;
        m_ptr   = 0;
        m_owner = 0;
        m_lock  = 1'b0;
    endtask

    task automatic reset_dut(string tag);
        drive();
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        reset_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic all_ready();
        cfu_cmd_rdy = 1'b1;
        cfu_rsp_en  = 1'b1;
        rsp_rdy_en  = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        all_ready();
        reset_model();
        reset_dut("reset");

        // Single transactions from idle with an always-ready Cfu
        vt[0] = '{0, 10'h007, 32'd5,        32'd3,  32'd8};
        vt[1] = '{1, 10'h00F, 32'd5,        32'd3,  32'd2};
        vt[2] = '{2, 10'h017, 32'd7,        32'd6,  32'd42};
        vt[3] = '{0, 10'h3FF, 32'hF0,       32'h0F, 32'hFF};
        vt[4] = '{1, 10'h007, 32'hFFFFFFFF, 32'd1,  32'd0};
        for (int k = 0; k < 5; k++) begin
            n0 = log_q.size();
            push_cmd(vt[k].req, vt[k].func, vt[k].a, vt[k].b, 1'b0);
            run_until_idle(20);
            check_eq("vec_count", log_q.size(), n0 + 1);
            if (log_q.size() == n0 + 1) begin
                check_eq("vec_req", log_q[n0].req, vt[k].req);
                check_eq("vec_data", log_q[n0].data, vt[k].exp);
                check_eq("vec_rsp_latency", log_q[n0].rsp_cyc - log_q[n0].acc_cyc, 3);
                check_eq("vec_done_latency", log_q[n0].done_cyc - log_q[n0].acc_cyc, 3);
            end
        end

        // Simultaneous requests right after reset: req0 first, then req1
        reset_dut("reset2");
        n0 = log_q.size();
        push_cmd(0, 10'h00F, 32'd5, 32'd3, 1'b0);
        push_cmd(1, 10'h017, 32'd5, 32'd3, 1'b0);
        run_until_idle(30);
        check_eq("both_count", log_q.size(), n0 + 2);
        if (log_q.size() == n0 + 2) begin
            check_eq("both_first", {log_q[n0].req, log_q[n0].data}, {32'd0, 32'd2});
            check_eq("both_second", {log_q[n0+1].req, log_q[n0+1].data}, {32'd1, 32'd15});
        end

        // req1 locks the Cfu over a MAC sequence while req0 keeps requesting
        reset_dut("reset3");
        n0 = log_q.size();
        push_cmd(1, 10'h000, 32'd2, 32'd3, 1'b1);
        push_cmd(1, 10'h000, 32'd4, 32'd5, 1'b1);
        push_cmd(1, 10'h008, 32'd0, 32'd0, 1'b0);
        tick();
        push_cmd(0, 10'h007, 32'd1, 32'd1, 1'b0);
        run_until_idle(60);
        check_eq("lock_count", log_q.size(), n0 + 4);
        if (log_q.size() == n0 + 4) begin
            check_eq("lock_order", {log_q[n0].req, log_q[n0+1].req, log_q[n0+2].req, log_q[n0+3].req},
                     {32'd1, 32'd1, 32'd1, 32'd0});
            check_eq("lock_data", {log_q[n0].data, log_q[n0+1].data, log_q[n0+2].data, log_q[n0+3].data},
                     {32'd6, 32'd26, 32'd26, 32'd2});
        end

        // Backpressure on every handshake: cmd_ready late 3, rsp 2 more, requester 2 more
        n0 = log_q.size();
        push_cmd(0, 10'h007, 32'd5, 32'd3, 1'b0);
        for (int r = 0; r < 14; r++) begin
            cfu_cmd_rdy   = (r >= 4);
            cfu_rsp_en    = (r >= 7);
            rsp_rdy_en[0] = (r >= 10);
            tick();
        end
        all_ready();
        check_eq("bp_count", log_q.size(), n0 + 1);
        if (log_q.size() == n0 + 1) begin
            check_eq("bp_data", log_q[n0].data, 8);
            check_eq("bp_rsp_latency", log_q[n0].rsp_cyc - log_q[n0].acc_cyc, 8);
            check_eq("bp_total_latency", log_q[n0].done_cyc - log_q[n0].acc_cyc, 10);
        end

        // Reset while waiting on the Cfu response drops the transaction
        n0 = log_q.size();
        push_cmd(1, 10'h007, 32'd1, 32'd2, 1'b0);
        cfu_rsp_en = 1'b0;
        repeat (3) tick();
        check_eq("mid_busy_before_reset", {busy, rsp_ready}, 2'b11);
        push_cmd(0, 10'h007, 32'd20, 32'd22, 1'b0);
        reset_dut("midreset");
        all_ready();
        run_until_idle(20);
        check_eq("post_reset_count", log_q.size(), n0 + 1);
        if (log_q.size() == n0 + 1)
            check_eq("post_reset_txn", {log_q[n0].req, log_q[n0].data}, {32'd0, 32'd42});

        // Randomized traffic against the transaction-level model
        n0 = log_q.size();
        begin
            int issued = 0;
            logic [9:0] funcs[5];
            funcs[0] = 10'h007; funcs[1] = 10'h00F; funcs[2] = 10'h017;
            funcs[3] = 10'h000; funcs[4] = 10'h008;
            for (int k = 0; k < 600; k++) begin
                int r;
                cfu_cmd_rdy = ($urandom_range(3) != 0);
                cfu_rsp_en  = ($urandom_range(2) != 0);
                for (int i = 0; i < NREQ; i++) rsp_rdy_en[i] = ($urandom_range(3) != 0);
                r = $urandom_range(NREQ - 1);
                if ($urandom_range(2) == 0 && pend[r].size() < 3) begin
                    if ($urandom_range(3) == 0) begin
                        push_cmd(r, funcs[$urandom_range(4)], $urandom, $urandom, 1'b1);
                        push_cmd(r, FUNC_W'($urandom), $urandom, $urandom, 1'b0);
                        issued += 2;
                    end else begin
                        push_cmd(r, funcs[$urandom_range(4)], $urandom_range(1000), $urandom_range(1000), 1'b0);
                        issued += 1;
                    end
                end
                tick();
            end
            all_ready();
            run_until_idle(400);
            check_eq("random_completed", log_q.size() - n0, issued);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_arbiter.md
# cfu_arbiter

Round-robin arbiter that shares one Cfu instance between NREQ requesters, each using the same cmd/rsp valid-ready protocol as the Cfu. At most one transaction is in flight. A per-requester lock keeps the grant across back-to-back transactions, so accumulator sequences (MAC_CLEAR, MAC_ACC…) are never interleaved with another requester's commands. Sits between the requesters (CPU port, streaming engines) and the Cfu cmd/rsp ports.

## Interface
- NREQ, 2, number of requesters (2..8)
- FUNC_W, 10, function_id width
- DATA_W, 32, operand/result width
- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- req_cmd_valid  in  [NREQ]  per-requester command valid
- req_cmd_ready  out  [NREQ]  per-requester command accepted
- req_cmd_function_id  in  [NREQ][FUNC_W]  command function id
- req_cmd_inputs_0 / req_cmd_inputs_1  in  [NREQ][DATA_W]  operands
- req_lock  in  [NREQ]  hold grant after this requester's response completes
- req_rsp_valid  out  [NREQ]  response valid to owner
- req_rsp_ready  in  [NREQ]  requester accepts response
- req_rsp_outputs_0  out  DATA_W  response data, shared bus, meaningful only where req_rsp_valid set
- cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1  out  1/FUNC_W/DATA_W/DATA_W  to Cfu
- cmd_ready  in  1  from Cfu
- rsp_valid, rsp_payload_outputs_0  in  1/DATA_W  from Cfu
- rsp_ready  out  1  to Cfu
- owner  out  $clog2(NREQ)  current grant index; busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RSP, DELIVER.
- IDLE: eligible = req_cmd_valid, masked to the lock owner only if a lock is held. If any eligible: pick with round-robin from pointer rr_ptr, latch function_id/inputs into payload regs, owner <= pick. req_cmd_ready[pick]=1 combinationally this cycle only. -> ISSUE.
- ISSUE: cmd_valid=1, payload from regs (stable). On cmd_ready -> WAIT_RSP.
- WAIT_RSP: rsp_ready=1. On rsp_valid, latch rsp_payload_outputs_0 -> DELIVER.
- DELIVER: req_rsp_valid[owner]=1 with latched data. On req_rsp_ready[owner] -> IDLE; rr_ptr <= owner+1 (mod NREQ); lock_held <= req_lock[owner] sampled this cycle.
- Lock held: other requesters wait regardless of their valid; released only when owner completes a DELIVER with req_lock low. rr_ptr still advances, so release resumes fair order.
- Round-robin: search from rr_ptr upward with wrap; NREQ=2 after reset gives req0 priority.
- Requester valid must stay high until ready (not checked). Payload changes after acceptance have no effect.
- Arbiter does not decode function_id; all ops forwarded verbatim.

## Timing
- Reset values: all req_cmd_ready/req_rsp_valid 0, cmd_valid 0, rsp_ready 0, payload regs 0, req_rsp_outputs_0 0, owner 0, busy 0, rr_ptr 0, lock_held 0, state IDLE.
- Best case (cmd_ready and rsp_valid already high): accept cycle 0, cmd_valid cycle 1, response latched cycle 2, req_rsp_valid cycle 3; back in IDLE cycle 4. Throughput one transaction per 4 cycles minimum.
- Cfu backpressure: each cycle cmd_ready low adds one cycle in ISSUE; each cycle rsp_valid low adds one in WAIT_RSP; requester rsp backpressure holds DELIVER.
- cmd_valid is never asserted with rsp_ready; no combinational path from req inputs to Cfu outputs (Cfu outputs from regs/state only).
- Reset mid-transaction: async return to IDLE, in-flight transaction dropped, lock cleared; Cfu shares the same reset.

## Structure
- Package cfu_arbiter_pkg: state enum, cfu_cmd_t struct (function_id, inputs_0, inputs_1), default widths.
- Sub-module cfu_rr_pick: combinational round-robin selector (request vector, pointer -> one-hot grant, index, any).

## Test plan
- Single req0 ADD (func 0x007, 5, 3), Cfu model ready always -> req_rsp_valid[0] at cycle 3 with 8; req1 rsp_valid never set.
- Both request in same IDLE after reset: req0 SUB (0x00F,5,3), req1 MUL (0x017,5,3) -> req0 gets 2 first, then req1 gets 15; owner 0 then 1.
- req1 lock high over three MAC commands (0x000,0x000,0x008) with req0 valid throughout -> all three forwarded to Cfu consecutively from req1; req0 granted only after lock drops.
- Cfu cmd_ready low 3 cycles, rsp_valid delayed 2 cycles, requester rsp_ready low 2 cycles -> payload stable in ISSUE, result 8 unchanged in DELIVER, total latency 10 cycles.
- reset asserted while in WAIT_RSP -> all outputs to reset values asynchronously; next request granted to req0 normally.
